// File: rtl/seq_divider_7bit.sv
// Iterative 7-bit unsigned restoring divider that retires one quotient bit per clock.
// Optional macro DIV_BY_ZERO_DETECT_EN short-circuits a zero divisor and flags div_by_zero.

module Cla7Adder (
  input  logic [6:0] a_i,
  input  logic [6:0] b_i,
  input  logic       cin_i,
  output logic [6:0] sum_o,
  output logic       cout_o
);

  logic [6:0] gen;
  logic [6:0] prop;
  logic [7:0] carry;

  // Each carry is the flattened generate/propagate chain, so no carry waits on its neighbour.
  always_comb begin : lookahead
    logic acc;
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    carry    = '0;
    carry[0] = cin_i;
    acc      = 1'b0;
    for (int i = 1; i < 8; i++) begin
      acc = cin_i;
      for (int j = 0; j < i; j++) begin
        acc = gen[j] | (prop[j] & acc);
      end
      carry[i] = acc;
    end
    sum_o  = prop ^ carry[6:0];
    cout_o = carry[7];
  end

endmodule

module seq_divider_7bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dividend,
  input  logic [6:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [6:0] quotient,
  output logic [6:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [6:0] r_q, r_d;
  logic [6:0] q_q, q_d;
  logic [6:0] d_q, d_d;
  logic [2:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [6:0] quot_q, quot_d;
  logic [6:0] rem_q, rem_d;

  logic [6:0] shifted;
  logic [6:0] trialSum;
  logic       trialCarry;
  logic       accept;
  logic       zeroRun;

`ifdef DIV_BY_ZERO_DETECT_EN
  logic zero_q, zero_d;
  logic dbz_q, dbz_d;
  assign zeroRun     = zero_q;
  assign div_by_zero = dbz_q;
`else
  assign zeroRun     = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  assign shifted = {r_q[5:0], q_q[6]};

  Cla7Adder u_sub (
    .a_i   (shifted),
    .b_i   (~d_q),
    .cin_i (1'b1),
    .sum_o (trialSum),
    .cout_o(trialCarry)
  );

  // R[6] means the shifted partial is at least 128, which always exceeds the divisor.
  assign accept = r_q[6] | trialCarry;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_BY_ZERO_DETECT_EN
    zero_d  = 1'b0;
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          count_d = '0;
          state_d = RUN;
`ifdef DIV_BY_ZERO_DETECT_EN
          if (divisor == 7'd0) zero_d = 1'b1;
          else                 busy_d = 1'b1;
`else
          busy_d  = 1'b1;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (zeroRun) begin
          quot_d  = 7'h7F;
          rem_d   = q_q;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef DIV_BY_ZERO_DETECT_EN
          dbz_d   = 1'b1;
`endif
        end else begin
          r_d     = accept ? trialSum : shifted;
          q_d     = {q_q[5:0], accept};
          count_d = count_q + 3'd1;
          if (count_q == 3'd6) begin
            quot_d  = q_d;
            rem_d   = r_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_d   = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_BY_ZERO_DETECT_EN
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider_7bit.sv
// Self-checking bench for seq_divider_7bit: directed table, corner sequences and a strided sweep.
// Honours DIV_BY_ZERO_DETECT_EN to choose the zero-divisor expectations.

module tb_seq_divider_7bit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] dividend;
  logic [6:0] divisor;
  logic       busy;
  logic       done;
  logic [6:0] quotient;
  logic [6:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [6:0] dvd;
    logic [6:0] dvs;
    logic [6:0] expQuot;
    logic [6:0] expRem;
  } vecT;

  typedef struct {
    logic [6:0] quot;
    logic [6:0] rem;
    logic       dbz;
    int         latency;
    int         acceptCycle;
  } expT;

  expT        sb[$];
  vecT        vecs[9];
  int         assertCount = 0;
  int         failCount = 0;
  int         cycleCount = 0;
  logic       prevDone = 1'b0;
  logic [6:0] heldQuot = '0;
  logic [6:0] heldRem = '0;
  logic       heldDbz = 1'b0;

  seq_divider_7bit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  function automatic expT makeExp(input logic [6:0] dvs, input logic [6:0] q, input logic [6:0] r);
    expT e;
    e.quot        = q;
    e.rem         = r;
    e.dbz         = 1'b0;
    e.latency     = 7;
    e.acceptCycle = 0;
`ifdef DIV_BY_ZERO_DETECT_EN
    if (dvs == 7'd0) begin
      e.dbz     = 1'b1;
      e.latency = 1;
    end
`else
    if (dvs == 7'd0) e.latency = 7;
`endif
    return e;
  endfunction

  // Drive one request on the negedge so it is accepted on the following rising edge.
  task automatic launch(input logic [6:0] dvd, input logic [6:0] dvs, input logic [6:0] q, input logic [6:0] r);
    expT e;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    e = makeExp(dvs, q, r);
    e.acceptCycle = cycleCount + 1;
    sb.push_back(e);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL completionTimeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic [6:0] dvd, input logic [6:0] dvs, input logic [6:0] q, input logic [6:0] r);
    @(negedge clk);
    launch(dvd, dvs, q, r);
    @(negedge clk);
    start = 1'b0;
    waitIdle();
  endtask

  // Scoreboard consumer: every done pops one expectation; otherwise outputs must hold.
  always @(negedge clk) begin
    expT e;
    if (!reset) begin
      if (done) begin
        checkOutput("doneSinglePulse", prevDone, 0);
        if (sb.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpectedDone: got done=1, expected no completion");
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", quotient, e.quot);
          checkOutput("remainder", remainder, e.rem);
          checkOutput("divByZero", div_by_zero, e.dbz);
          checkOutput("latency", cycleCount - e.acceptCycle, e.latency);
          checkOutput("busyAtDone", busy, 0);
          heldQuot = e.quot;
          heldRem  = e.rem;
          heldDbz  = e.dbz;
        end
      end else begin
        checkOutput("heldQuotient", quotient, heldQuot);
        checkOutput("heldRemainder", remainder, heldRem);
        checkOutput("heldDivByZero", div_by_zero, heldDbz);
      end
    end
    prevDone = done;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCycles;
    int n;
    logic [6:0] a;
    logic [6:0] b;

    vecs[0] = '{7'd100, 7'd7,   7'd14,  7'd2};
    vecs[1] = '{7'd127, 7'd1,   7'd127, 7'd0};
    vecs[2] = '{7'd5,   7'd9,   7'd0,   7'd5};
    vecs[3] = '{7'd126, 7'd127, 7'd0,   7'd126};
    vecs[4] = '{7'd45,  7'd0,   7'd127, 7'd45};
    vecs[5] = '{7'd99,  7'd4,   7'd24,  7'd3};
    vecs[6] = '{7'd0,   7'd1,   7'd0,   7'd0};
    vecs[7] = '{7'd127, 7'd127, 7'd1,   7'd0};
    vecs[8] = '{7'd50,  7'd3,   7'd16,  7'd2};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetQuotient", quotient, 0);
    checkOutput("resetRemainder", remainder, 0);
    checkOutput("resetDivByZero", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] 100/7 latency and busy width");
    @(negedge clk);
    launch(7'd100, 7'd7, 7'd14, 7'd2);
    @(negedge clk);
    start = 1'b0;
    busyCycles = 0;
    n = 0;
    while (busy && n < 20) begin
      busyCycles++;
      @(negedge clk);
      n++;
    end
    checkOutput("busyCycles", busyCycles, 7);
    checkOutput("doneAfterBusy", done, 1);
    waitIdle();

    $display("[TB] start ignored while busy, then back-to-back");
    @(negedge clk);
    launch(7'd100, 7'd7, 7'd14, 7'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dividend = 7'd50;
      divisor  = 7'd3;
    end
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("firstDoneSeen", done, 1);
    launch(7'd50, 7'd3, 7'd16, 7'd2);
    @(negedge clk);
    start = 1'b0;
    checkOutput("backToBackBusy", busy, 1);
    checkOutput("backToBackDoneDrop", done, 0);
    waitIdle();

    $display("[TB] reset mid-operation");
    @(negedge clk);
    start    = 1'b1;
    dividend = 7'd99;
    divisor  = 7'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    heldQuot = '0;
    heldRem  = '0;
    heldDbz  = 1'b0;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortQuotient", quotient, 0);
    checkOutput("abortRemainder", remainder, 0);
    checkOutput("abortDivByZero", div_by_zero, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    applyStimulus(7'd99, 7'd4, 7'd24, 7'd3);

    $display("[TB] directed table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs, vecs[i].expQuot, vecs[i].expRem);
    end

    $display("[TB] strided sweep and random pairs");
    for (int x = 0; x < 128; x += 3) begin
      for (int y = 1; y < 128; y += 5) begin
        a = x[6:0];
        b = y[6:0];
        applyStimulus(a, b, a / b, a % b);
      end
    end
    for (int k = 0; k < 200; k++) begin
      a = 7'($urandom_range(0, 127));
      b = 7'($urandom_range(1, 127));
      applyStimulus(a, b, a / b, a % b);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
